// File: rtl/median_window_filter_if.sv
// Streaming sample/result bundle for the sliding-window median filter.
// The master drives samples and control; the slave (the filter) returns
// min/median/max of each completed window.
interface median_window_filter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  flush;
    logic                  inValid;
    logic [DATA_WIDTH-1:0] inData;
    logic                  bypassEn;
    logic                  outValid;
    logic [DATA_WIDTH-1:0] outLow;
    logic [DATA_WIDTH-1:0] outMedian;
    logic [DATA_WIDTH-1:0] outHigh;

    modport master (
        output flush, inValid, inData, bypassEn,
        input  outValid, outLow, outMedian, outHigh
    );

    modport slave (
        input  flush, inValid, inData, bypassEn,
        output outValid, outLow, outMedian, outHigh
    );
endinterface

// File: rtl/median_window_filter.sv
// Sliding-window median filter. The last WINDOW_SIZE accepted samples are
// held in a shift register and sorted by a fully registered odd-even
// transposition network (one compare-exchange phase per stage). The final
// phase feeds the output registers directly, so a sample presented in cycle n
// yields its result in cycle n+WINDOW_SIZE+1. A valid tag, a bypass flag and
// the raw sample travel alongside the window through every stage.
module median_window_filter #(
    parameter int DATA_WIDTH  = 8,
    parameter int WINDOW_SIZE = 3,
    parameter bit DATA_SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    median_window_filter_if.slave bus
);

    localparam int FW  = $clog2(WINDOW_SIZE + 1);
    localparam int MID = (WINDOW_SIZE - 1) / 2;
    localparam logic [FW-1:0] FILL_MAX = FW'(WINDOW_SIZE);

    typedef logic [DATA_WIDTH-1:0] sample_t;
    typedef logic [WINDOW_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

    generate
        if (WINDOW_SIZE < 3 || WINDOW_SIZE > 9 || (WINDOW_SIZE % 2) == 0) begin : g_bad_window
            $error("median_window_filter: WINDOW_SIZE must be odd and within 3..9");
        end
        if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
            $error("median_window_filter: DATA_WIDTH must be within 2..32");
        end
    endgenerate

    function automatic logic greater(input sample_t a, input sample_t b);
        if (DATA_SIGNED) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

    // One transposition phase: order the pairs (i,i+1) whose lower index has
    // the given parity. Equal values stay in place.
    function automatic vec_t sort_step(input vec_t v, input int parity);
        vec_t o;
        o = v;
        for (int i = 0; i < WINDOW_SIZE - 1; i++) begin
            if ((i % 2) == parity && greater(v[i], v[i+1])) begin
                o[i]   = v[i+1];
                o[i+1] = v[i];
            end
        end
        return o;
    endfunction

    // stage 0: window, fill count and per-sample tags
    vec_t          r_win;
    logic [FW-1:0] r_fill;
    logic          r_tag0;
    logic          r_byp0;
    sample_t       r_bdat0;

    // stages 1..WINDOW_SIZE-1: registered sort phases
    vec_t                   r_stg    [1:WINDOW_SIZE-1];
    sample_t                r_bdat_p [1:WINDOW_SIZE-1];
    logic [WINDOW_SIZE-1:1] r_tag_p;
    logic [WINDOW_SIZE-1:1] r_byp_p;

    // final stage: output registers
    logic    r_out_valid;
    sample_t r_out_low;
    sample_t r_out_med;
    sample_t r_out_high;

    vec_t          w_in   [1:WINDOW_SIZE];
    vec_t          w_step [1:WINDOW_SIZE];
    logic [FW-1:0] w_fill_inc;
    logic          w_full;

    // Saturating fill count and "window complete" flag for the incoming sample.
    always_comb begin
        w_fill_inc = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + FW'(1);
        w_full     = (w_fill_inc == FILL_MAX);
    end

    // Compare-exchange network feeding each registered stage.
    always_comb begin
        w_in[1] = r_win;
        for (int s = 2; s <= WINDOW_SIZE; s++) begin
            w_in[s] = r_stg[s-1];
        end
        for (int s = 1; s <= WINDOW_SIZE; s++) begin
            w_step[s] = sort_step(w_in[s], s % 2);
        end
    end

    // Window shift, fill tracking and tag generation; flush restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_fill  <= '0;
            r_tag0  <= 1'b0;
            r_byp0  <= 1'b0;
            r_bdat0 <= '0;
        end else begin
            r_bdat0 <= bus.inData;
            r_byp0  <= bus.inValid & bus.bypassEn;
            if (bus.flush) begin
                // A sample arriving with flush becomes the first of the new window.
                r_tag0 <= bus.inValid & bus.bypassEn;
                if (bus.inValid) begin
                    r_win  <= {{((WINDOW_SIZE-1)*DATA_WIDTH){1'b0}}, bus.inData};
                    r_fill <= FW'(1);
                end else begin
                    r_win  <= '0;
                    r_fill <= '0;
                end
            end else begin
                r_tag0 <= bus.inValid & (w_full | bus.bypassEn);
                if (bus.inValid) begin
                    r_win  <= {r_win[WINDOW_SIZE-2:0], bus.inData};
                    r_fill <= w_fill_inc;
                end
            end
        end
    end

    // Sort pipeline advances every clock; flush drops all in-flight tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_p <= '0;
            r_byp_p <= '0;
            for (int s = 1; s < WINDOW_SIZE; s++) begin
                r_stg[s]    <= '0;
                r_bdat_p[s] <= '0;
            end
        end else begin
            r_tag_p     <= bus.flush ? '0 : {r_tag_p[WINDOW_SIZE-2:1], r_tag0};
            r_byp_p     <= {r_byp_p[WINDOW_SIZE-2:1], r_byp0};
            r_stg[1]    <= w_step[1];
            r_bdat_p[1] <= r_bdat0;
            for (int s = 2; s < WINDOW_SIZE; s++) begin
                r_stg[s]    <= w_step[s];
                r_bdat_p[s] <= r_bdat_p[s-1];
            end
        end
    end

    // Output registers load only for a valid result and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_low   <= '0;
            r_out_med   <= '0;
            r_out_high  <= '0;
        end else begin
            r_out_valid <= r_tag_p[WINDOW_SIZE-1] & ~bus.flush;
            if (r_tag_p[WINDOW_SIZE-1] && !bus.flush) begin
                if (r_byp_p[WINDOW_SIZE-1]) begin
                    r_out_low  <= r_bdat_p[WINDOW_SIZE-1];
                    r_out_med  <= r_bdat_p[WINDOW_SIZE-1];
                    r_out_high <= r_bdat_p[WINDOW_SIZE-1];
                end else begin
                    r_out_low  <= w_step[WINDOW_SIZE][0];
                    r_out_med  <= w_step[WINDOW_SIZE][MID];
                    r_out_high <= w_step[WINDOW_SIZE][WINDOW_SIZE-1];
                end
            end
        end
    end

    assign bus.outValid  = r_out_valid;
    assign bus.outLow    = r_out_low;
    assign bus.outMedian = r_out_med;
    assign bus.outHigh   = r_out_high;

endmodule

// File: tb/tb_median_window_filter.sv
// Directed bench for median_window_filter: three instances (W=3 unsigned,
// W=3 signed, W=5 unsigned), per-cycle expected tables written by hand.
module tb_median_window_filter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    median_window_filter_if #(.DATA_WIDTH(8)) bu ();
    median_window_filter_if #(.DATA_WIDTH(8)) bs ();
    median_window_filter_if #(.DATA_WIDTH(8)) b5 ();

    median_window_filter #(.DATA_WIDTH(8), .WINDOW_SIZE(3), .DATA_SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .bus(bu)
    );
    median_window_filter #(.DATA_WIDTH(8), .WINDOW_SIZE(3), .DATA_SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bs)
    );
    median_window_filter #(.DATA_WIDTH(8), .WINDOW_SIZE(5), .DATA_SIGNED(1'b0)) u_dut_5 (
        .clk(clk), .rst_n(rst_n), .bus(b5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bu.flush = 1'b0; bu.inValid = 1'b0; bu.inData = 8'd0; bu.bypassEn = 1'b0;
        bs.flush = 1'b0; bs.inValid = 1'b0; bs.inData = 8'd0; bs.bypassEn = 1'b0;
        b5.flush = 1'b0; b5.inValid = 1'b0; b5.inData = 8'd0; b5.bypassEn = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bu.outValid, bu.outLow, bu.outMedian, bu.outHigh} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_u: got %h, want 0", {bu.outValid, bu.outLow, bu.outMedian, bu.outHigh});
        end
        n_vec++;
        if ({bs.outValid, bs.outLow, bs.outMedian, bs.outHigh} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_s: got %h, want 0", {bs.outValid, bs.outLow, bs.outMedian, bs.outHigh});
        end
        n_vec++;
        if ({b5.outValid, b5.outLow, b5.outMedian, b5.outHigh} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_5: got %h, want 0", {b5.outValid, b5.outLow, b5.outMedian, b5.outHigh});
        end
    endtask

    task automatic test_basic();
        logic [7:0]  d;
        logic [23:0] ex;
        for (int c = 0; c < 10; c++) begin
            case (c)
                0: d = 8'd5;
                1: d = 8'd1;
                2: d = 8'd9;
                3: d = 8'd3;
                4: d = 8'd3;
                default: d = 8'd0;
            endcase
            bu.inValid = (c < 5);
            bu.inData  = d;
            n_vec++;
            if (bu.outValid !== (c >= 6 && c <= 8)) begin
                n_err++;
                $display("FAIL basic_valid cycle %0d: got %b, want %b", c, bu.outValid, (c >= 6 && c <= 8));
            end
            if (c >= 6) begin
                if (c == 6)      ex = {8'd1, 8'd5, 8'd9};
                else if (c == 7) ex = {8'd1, 8'd3, 8'd9};
                else             ex = {8'd3, 8'd3, 8'd9};
                n_vec++;
                if ({bu.outLow, bu.outMedian, bu.outHigh} !== ex) begin
                    n_err++;
                    $display("FAIL basic_data cycle %0d: got %h, want %h", c, {bu.outLow, bu.outMedian, bu.outHigh}, ex);
                end
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_signed();
        logic [7:0] d;
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: d = 8'h80;
                1: d = 8'h01;
                2: d = 8'hFF;
                default: d = 8'h00;
            endcase
            bu.inValid = (c < 3); bu.inData = d;
            bs.inValid = (c < 3); bs.inData = d;
            n_vec++;
            if ({bu.outValid, bs.outValid} !== {2{c == 6}}) begin
                n_err++;
                $display("FAIL signed_valid cycle %0d: got %b, want %b", c, {bu.outValid, bs.outValid}, {2{c == 6}});
            end
            if (c >= 6) begin
                n_vec++;
                if ({bu.outLow, bu.outMedian, bu.outHigh} !== 24'h0180FF) begin
                    n_err++;
                    $display("FAIL unsigned_order cycle %0d: got %h, want 0180ff", c, {bu.outLow, bu.outMedian, bu.outHigh});
                end
                n_vec++;
                if ({bs.outLow, bs.outMedian, bs.outHigh} !== 24'h80FF01) begin
                    n_err++;
                    $display("FAIL signed_order cycle %0d: got %h, want 80ff01", c, {bs.outLow, bs.outMedian, bs.outHigh});
                end
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_window5_gaps();
        logic [7:0]  d;
        logic [23:0] ex;
        for (int c = 0; c < 19; c++) begin
            case (c)
                0:  d = 8'd10;
                2:  d = 8'd50;
                4:  d = 8'd20;
                6:  d = 8'd40;
                8:  d = 8'd30;
                default: d = 8'd0;
            endcase
            b5.inValid = ((c % 2) == 0 && c <= 10);
            b5.inData  = d;
            n_vec++;
            if (b5.outValid !== (c == 14 || c == 16)) begin
                n_err++;
                $display("FAIL w5_valid cycle %0d: got %b, want %b", c, b5.outValid, (c == 14 || c == 16));
            end
            if (c >= 14) begin
                ex = (c < 16) ? {8'd10, 8'd30, 8'd50} : {8'd0, 8'd30, 8'd50};
                n_vec++;
                if ({b5.outLow, b5.outMedian, b5.outHigh} !== ex) begin
                    n_err++;
                    $display("FAIL w5_data cycle %0d: got %h, want %h", c, {b5.outLow, b5.outMedian, b5.outHigh}, ex);
                end
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_flush();
        logic [7:0] d;
        for (int c = 0; c < 17; c++) begin
            case (c)
                0:  d = 8'd7;
                1:  d = 8'd8;
                2:  d = 8'd9;
                3:  d = 8'd1;
                4:  d = 8'd2;
                10: d = 8'd7;
                default: d = 8'd0;
            endcase
            bu.inValid = (c <= 4 || c == 10);
            bu.inData  = d;
            bu.flush   = (c == 2 || c == 12);
            n_vec++;
            if (bu.outValid !== (c == 8)) begin
                n_err++;
                $display("FAIL flush_valid cycle %0d: got %b, want %b", c, bu.outValid, (c == 8));
            end
            if (c >= 8) begin
                n_vec++;
                if ({bu.outLow, bu.outMedian, bu.outHigh} !== {8'd1, 8'd2, 8'd9}) begin
                    n_err++;
                    $display("FAIL flush_data cycle %0d: got %h, want 010209", c, {bu.outLow, bu.outMedian, bu.outHigh});
                end
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_bypass();
        logic [7:0]  d;
        logic [23:0] ex;
        for (int c = 0; c < 9; c++) begin
            case (c)
                0: d = 8'd42;
                1: d = 8'd6;
                2: d = 8'd3;
                default: d = 8'd0;
            endcase
            bu.inValid  = (c <= 2);
            bu.inData   = d;
            bu.bypassEn = (c == 0);
            n_vec++;
            if (bu.outValid !== (c == 4 || c == 6)) begin
                n_err++;
                $display("FAIL bypass_valid cycle %0d: got %b, want %b", c, bu.outValid, (c == 4 || c == 6));
            end
            if (c >= 4) begin
                ex = (c < 6) ? {8'd42, 8'd42, 8'd42} : {8'd3, 8'd6, 8'd42};
                n_vec++;
                if ({bu.outLow, bu.outMedian, bu.outHigh} !== ex) begin
                    n_err++;
                    $display("FAIL bypass_data cycle %0d: got %h, want %h", c, {bu.outLow, bu.outMedian, bu.outHigh}, ex);
                end
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: d = 8'd5;
                1: d = 8'd1;
                2: d = 8'd9;
                default: d = 8'd0;
            endcase
            bu.inValid = (c < 3);
            bu.inData  = d;
            tick();
        end
        idle_all();
        n_vec++;
        if ({bu.outValid, bu.outLow, bu.outMedian, bu.outHigh} !== {1'b1, 8'd1, 8'd5, 8'd9}) begin
            n_err++;
            $display("FAIL arst_pre: got %h, want 1010509", {bu.outValid, bu.outLow, bu.outMedian, bu.outHigh});
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bu.outValid, bu.outLow, bu.outMedian, bu.outHigh} !== 25'd0) begin
            n_err++;
            $display("FAIL arst_immediate: got %h, want 0", {bu.outValid, bu.outLow, bu.outMedian, bu.outHigh});
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: d = 8'd4;
                1: d = 8'd5;
                2: d = 8'd6;
                default: d = 8'd0;
            endcase
            bu.inValid = (c < 3);
            bu.inData  = d;
            n_vec++;
            if (bu.outValid !== (c == 6)) begin
                n_err++;
                $display("FAIL arst_restart_valid cycle %0d: got %b, want %b", c, bu.outValid, (c == 6));
            end
            if (c == 6) begin
                n_vec++;
                if ({bu.outLow, bu.outMedian, bu.outHigh} !== {8'd4, 8'd5, 8'd6}) begin
                    n_err++;
                    $display("FAIL arst_restart_data: got %h, want 040506", {bu.outLow, bu.outMedian, bu.outHigh});
                end
            end
            tick();
        end
        idle_all();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        idle_all();
        test_reset();
        do_reset();
        test_basic();
        do_reset();
        test_signed();
        do_reset();
        test_window5_gaps();
        do_reset();
        test_flush();
        do_reset();
        test_bypass();
        do_reset();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
